// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding,
// default operand width and the counter-width helper.
package sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam int SUB_WIDTH_DEF = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sub_bit.sv
// One-bit full subtractor cell; mirror of the ripple adder's bit cell.
module sub_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor X - Y, LSB first, valid/ready on both sides.
// SERIAL_SUB_SAT_EN: clamp diff to 0 when the final borrow is set.
module serial_sub
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] xs_q, xs_d;
    logic [WIDTH-1:0] ys_q, ys_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bin_q, bin_d;
    logic             bor_q, bor_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             bit_d;
    logic             bit_bout;

    sub_bit u_bit (
        .a    (xs_q[0]),
        .b    (ys_q[0]),
        .bin  (bin_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        acc_d   = acc_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bor_d   = bor_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    xs_d    = x;
                    ys_d    = y;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                xs_d  = xs_q >> 1;
                ys_d  = ys_q >> 1;
                acc_d = {bit_d, acc_q[WIDTH-1:1]};
                bin_d = bit_bout;
                cnt_d = cnt_q + 1'b1;
                // Last bit: publish result to the held output registers
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    bor_d   = bit_bout;
`ifdef SERIAL_SUB_SAT_EN
                    diff_d  = bit_bout ? '0 : acc_d;
`else
                    diff_d  = acc_d;
`endif
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            xs_q        <= '0;
            ys_q        <= '0;
            acc_q       <= '0;
            diff_q      <= '0;
            cnt_q       <= '0;
            bin_q       <= 1'b0;
            bor_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            xs_q        <= xs_d;
            ys_q        <= ys_d;
            acc_q       <= acc_d;
            diff_q      <= diff_d;
            cnt_q       <= cnt_d;
            bin_q       <= bin_d;
            bor_q       <= bor_d;
            in_ready_q  <= (state_d == S_IDLE);
            out_valid_q <= (state_d == S_DONE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = bor_q;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=4) using an expected-result queue.
module tb_serial_sub;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;

    int vectors;
    int errors;

    logic [W:0] sb_q[$];

    serial_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        logic [W-1:0] d;
        logic         bo;
        d  = a - b;
        bo = (a < b);
`ifdef SERIAL_SUB_SAT_EN
        if (bo) d = '0;
`endif
        return {bo, d};
    endfunction

    // Accept an operand pair; returns edges from accept edge to out_valid.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        x = a;
        y = b;
        sb_q.push_back(model(a, b));
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            guard++;
        end
    endtask

    // Stall out_ready, check hold, then complete the handshake and compare.
    task automatic recv(input string nm, input int stall);
        logic [W:0] exp;
        logic [W-1:0] d0;
        logic         b0;
        vectors++;
        if (!out_valid) begin
            errors++;
            $display("FAIL %s_timeout: out_valid=%b required 1", nm, out_valid);
            void'(sb_q.pop_front());
            return;
        end
        d0 = diff;
        b0 = borrow;
        out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || diff !== d0 || borrow !== b0 ||
                in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s_hold: v=%b d=%h b=%b rdy=%b required 1 %h %b 0",
                         nm, out_valid, diff, borrow, in_ready, d0, b0);
            end
        end
        out_ready = 1'b1;
        exp = sb_q.pop_front();
        vectors++;
        if (diff !== exp[W-1:0] || borrow !== exp[W]) begin
            errors++;
            $display("FAIL %s_result: diff=%h borrow=%b required %h %b",
                     nm, diff, borrow, exp[W-1:0], exp[W]);
        end
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: out_valid=%b in_ready=%b required 0 1",
                     nm, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        x = '0;
        y = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== '0 ||
            borrow !== 1'b0) begin
            errors++;
            $display("FAIL reset: rdy=%b v=%b d=%h b=%b required 1 0 0 0",
                     in_ready, out_valid, diff, borrow);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        send(4'd9, 4'd3, lat);
        vectors++;
        if (lat !== W + 1) begin
            errors++;
            $display("FAIL latency: edges=%0d required %0d", lat, W + 1);
        end
        recv("sub_9_3", 0);
        send(4'd3, 4'd9, lat);
        recv("sub_3_9", 0);
        send(4'd0, 4'd1, lat);
        recv("sub_0_1", 0);
    endtask

    task automatic test_back_to_back();
        int lat;
        send(4'd15, 4'd15, lat);
        recv("sub_15_15", 0);
        send(4'd0, 4'd0, lat);
        recv("sub_0_0", 0);
    endtask

    task automatic test_backpressure();
        int lat;
        send(4'd12, 4'd5, lat);
        in_valid = 1'b1;
        x = 4'd1;
        y = 4'd1;
        recv("bp_12_5", 6);
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ignored_in: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit seen;
        @(negedge clk);
        in_valid = 1'b1;
        x = 4'd8;
        y = 4'd2;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== '0 ||
            borrow !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: rdy=%b v=%b d=%h b=%b required 1 0 0 0",
                     in_ready, out_valid, diff, borrow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            errors++;
            $display("FAIL reset_discard: out_valid seen=1 required 0");
        end
        send(4'd5, 4'd4, lat);
        recv("after_reset", 0);
    endtask

    task automatic test_sweep();
        int lat;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                send(W'(a), W'(b), lat);
                recv("sweep", $urandom_range(0, 2));
            end
        end
    endtask

    initial begin
        vectors = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
